leitor_posicoes: RTL and testbench
==================================

Name: leitor_posicoes

Overview:
- Reader side of the packed asteroid-position word {coor_x, coor_y, opcode} stored in position memory.
- On a start request, scans memory addresses 0..NUM_ENTRIES-1 in order and splits each packed word into its fields.
- Delivers each entry with a valid/ready handshake to the downstream consumer (collision check or display driver), then pulses a done flag.

Parameters:
- N, 4, width of each coordinate field; the packed word is 2N+2 bits.
- ADDR_W, 4, memory address width.
- NUM_ENTRIES, 16, number of entries scanned per pass; range 1..2^ADDR_W.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start a scan pass; sampled only in OCIOSO.
- mem_dado  in  2N+2  read data from position memory. Synchronous RAM: data is valid the cycle after the address is presented.
- mem_endereco  out  ADDR_W  memory read address.
- mem_leitura  out  1  read enable to memory.
- coor_x  out  N  unpacked X, mem_dado[2N+1:N+2].
- coor_y  out  N  unpacked Y, mem_dado[N+1:2].
- opcode  out  2  unpacked opcode, mem_dado[1:0].
- endereco_atual  out  ADDR_W  address of the entry currently on coor_x/coor_y/opcode.
- valido  out  1  entry on the outputs is valid.
- pronto  in  1  consumer accepts the entry.
- ocupado  out  1  high in every state except OCIOSO.
- fim  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = OCIOSO;
  - all outputs = 0;
  - internal address counter = 0.
- Reset wins over every other input, including mid-scan and during ENTREGA. No fim is generated for an aborted pass.
- States and transitions:
  - OCIOSO: wait. If iniciar=1, clear the counter to 0 and go to LE.
  - LE: drive mem_endereco = counter and mem_leitura = 1 for exactly one cycle, then go to ESPERA.
  - ESPERA: mem_leitura = 0; wait for RAM data. At the end of this cycle, register the fields from mem_dado and set endereco_atual = counter. Go to ENTREGA.
  - ENTREGA: valido = 1; coor_x, coor_y, opcode and endereco_atual are held stable.
    - If pronto = 1 at a rising edge, that is a transfer.
    - If counter = NUM_ENTRIES-1, go to FIM.
    - Otherwise increment counter and go to LE.
  - FIM: fim = 1 and valido = 0 for one cycle, then go to OCIOSO.
- Timing:
  - iniciar is sampled at edge k.
  - mem_leitura is high in cycle k+1.
  - valido rises in cycle k+3.
  - With pronto held at 1, one entry every 3 cycles.
  - fim is asserted the cycle after the last transfer.
- valido drops in the cycle after a transfer.
- Data outputs keep their last value outside ENTREGA; the consumer qualifies them with valido.
- Backpressure: while pronto = 0 in ENTREGA, the outputs and the counter stay unchanged indefinitely. No extra memory reads are issued.
- iniciar is ignored in every state other than OCIOSO, including FIM. A new pass needs iniciar in OCIOSO.
- NUM_ENTRIES = 1: one LE/ESPERA/ENTREGA cycle, then FIM.
- Counter behaviour:
  - never exceeds NUM_ENTRIES-1;
  - no wrap within a pass;
  - mem_endereco is 0 whenever mem_leitura = 0.
- The field split is pure bit-slicing: no sign extension, no arithmetic.

Test Plan:
1. Reset:
   - Stimulus: assert reset for 2 cycles with iniciar = 1 and random mem_dado.
   - Required: all outputs 0 and state OCIOSO throughout; after release with iniciar low, ocupado = 0.
2. Full pass (NUM_ENTRIES = 4, N = 4):
   - Stimulus: memory = {10'b1010_0101_11, 10'b0001_1111_00, 10'b1111_0000_10, 10'b0110_1001_01}; pronto tied to 1.
   - Required outputs:
     - entry 0: (x=10, y=5, op=3);
     - entry 1: (1, 15, 0);
     - entry 2: (15, 0, 2);
     - entry 3: (6, 9, 1).
   - Required timing: first valido 3 cycles after iniciar; one entry every 3 cycles; single fim pulse after entry 3.
3. Backpressure:
   - Stimulus: hold pronto = 0 for 5 cycles on entry 1.
   - Required: x=1, y=15, op=0 and endereco_atual=1 held stable; mem_leitura stays 0; entry 2 follows 3 cycles after pronto rises.
4. Ignored start:
   - Stimulus: pulse iniciar during ENTREGA of entry 2, and again during FIM.
   - Required: the pass is unaffected; exactly one fim; return to OCIOSO with ocupado = 0.
5. Reset mid-scan:
   - Stimulus: assert reset while valido = 1 on entry 1.
   - Required: next cycle all outputs 0 and no fim; a later iniciar restarts from address 0.
6. Parameter check (N = 5, NUM_ENTRIES = 1):
   - Stimulus: mem_dado = 12'b10011_01100_10.
   - Required: x=19, y=12, op=2; fim asserted the cycle after the transfer.

Source files
------------

// File: rtl/leitor_posicoes_if.sv
// Purpose: bundles the start/done, position-memory read and entry-delivery signals of the position reader.
// Latency: none, wires only.
// Backpressure: carries valido/pronto; the reader holds its entry while pronto is low.
interface leitor_posicoes_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 4
) ();
  logic              iniciar;
  logic              ocupado;
  logic              fim;
  logic [2*N+1:0]    mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic              mem_leitura;
  logic [N-1:0]      coor_x;
  logic [N-1:0]      coor_y;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] endereco_atual;
  logic              valido;
  logic              pronto;

  // Reader side: drives memory address/enable and the unpacked entry stream.
  modport master (
    input  iniciar, mem_dado, pronto,
    output ocupado, fim, mem_endereco, mem_leitura,
           coor_x, coor_y, opcode, endereco_atual, valido
  );

  // Environment side: memory plus downstream consumer plus controller.
  modport slave (
    output iniciar, mem_dado, pronto,
    input  ocupado, fim, mem_endereco, mem_leitura,
           coor_x, coor_y, opcode, endereco_atual, valido
  );
endinterface

// File: rtl/leitor_posicoes.sv
// Purpose: scans position memory 0..NUM_ENTRIES-1 and unpacks each {x, y, opcode} word for a consumer.
// Latency: first valido 3 cycles after iniciar is sampled; one entry every 3 cycles with pronto high.
// Backpressure: entry, counter and memory port freeze while valido is high and pronto is low.
module leitor_posicoes #(
  parameter int N           = 4,
  parameter int ADDR_W      = 4,
  parameter int NUM_ENTRIES = 16
) (
  input  logic               clock,
  input  logic               reset,
  leitor_posicoes_if.master  bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    LE,
    ESPERA,
    ENTREGA,
    FIM
  } estado_t;

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(NUM_ENTRIES - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] cont_q, cont_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      y_q, y_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              transfere;

  assign transfere = (estado_q == ENTREGA) && bus.pronto;

  // State register; reset aborts any pass without producing fim.
  always_ff @(posedge clock) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  // Next-state: one read, one wait for the synchronous RAM, then hold until accepted.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (bus.iniciar) estado_d = LE;
      LE:      estado_d = ESPERA;
      ESPERA:  estado_d = ENTREGA;
      ENTREGA: if (transfere) estado_d = (cont_q == ULTIMO) ? FIM : LE;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Datapath next values: counter cleared on start, stepped on a non-final transfer; fields captured as RAM data lands.
  always_comb begin
    cont_d = cont_q;
    x_d    = x_q;
    y_d    = y_q;
    op_d   = op_q;
    end_d  = end_q;
    if (estado_q == OCIOSO && bus.iniciar) cont_d = '0;
    if (transfere && cont_q != ULTIMO)     cont_d = cont_q + 1'b1;
    if (estado_q == ESPERA) begin
      x_d   = bus.mem_dado[2*N+1:N+2];
      y_d   = bus.mem_dado[N+1:2];
      op_d  = bus.mem_dado[1:0];
      end_d = cont_q;
    end
  end

  // Datapath registers; outputs keep their last value outside ENTREGA.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= '0;
      end_q  <= '0;
    end else begin
      cont_q <= cont_d;
      x_q    <= x_d;
      y_q    <= y_d;
      op_q   <= op_d;
      end_q  <= end_d;
    end
  end

  // Outputs decoded from state; address is forced to 0 whenever no read is issued.
  always_comb begin
    bus.mem_leitura    = (estado_q == LE);
    bus.mem_endereco   = (estado_q == LE) ? cont_q : '0;
    bus.valido         = (estado_q == ENTREGA);
    bus.ocupado        = (estado_q != OCIOSO);
    bus.fim            = (estado_q == FIM);
    bus.coor_x         = x_q;
    bus.coor_y         = y_q;
    bus.opcode         = op_q;
    bus.endereco_atual = end_q;
  end

endmodule

// File: tb/tb_leitor_posicoes.sv
// Purpose: directed self-checking bench for leitor_posicoes in two configurations (N=4/4 entries, N=5/1 entry).
// Latency: expects first valido 3 cycles after iniciar and 3 cycles per entry.
// Backpressure: stalls the consumer for 5 cycles on one entry and checks the hold.
module tb_leitor_posicoes;

  logic clock;
  logic reset;

  leitor_posicoes_if #(.N(4), .ADDR_W(4)) if_a ();
  leitor_posicoes_if #(.N(5), .ADDR_W(4)) if_b ();

  leitor_posicoes #(.N(4), .ADDR_W(4), .NUM_ENTRIES(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.master)
  );

  leitor_posicoes #(.N(5), .ADDR_W(4), .NUM_ENTRIES(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.master)
  );

  logic [9:0]  mem_a [0:15];
  logic [11:0] mem_b [0:15];
  logic [9:0]  ram_a_q = '0;
  logic [11:0] ram_b_q = '0;
  logic        modo_aleat;
  logic [9:0]  dado_aleat;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_fim_a = 0;
  int n_fim_b = 0;
  int fim_ref;

  int ex [4] = '{10, 1, 15, 6};
  int ey [4] = '{5, 15, 0, 9};
  int eo [4] = '{3, 0, 2, 1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM models: data appears the cycle after the read address.
  always @(posedge clock) begin
    if (if_a.mem_leitura === 1'b1) ram_a_q <= mem_a[if_a.mem_endereco];
    if (if_b.mem_leitura === 1'b1) ram_b_q <= mem_b[if_b.mem_endereco];
  end

  assign if_a.mem_dado = modo_aleat ? dado_aleat : ram_a_q;
  assign if_b.mem_dado = ram_b_q;

  // Count fim pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (if_a.fim === 1'b1) n_fim_a++;
    if (if_b.fim === 1'b1) n_fim_b++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check(tag, 32'({if_a.mem_endereco, if_a.mem_leitura, if_a.coor_x, if_a.coor_y, if_a.opcode,
                    if_a.endereco_atual, if_a.valido, if_a.ocupado, if_a.fim}), 32'd0);
  endtask

  task automatic check_entrega(input int e);
    check("ent_valido",  32'(if_a.valido), 32'd1);
    check("ent_x",       32'(if_a.coor_x), ex[e]);
    check("ent_y",       32'(if_a.coor_y), ey[e]);
    check("ent_op",      32'(if_a.opcode), eo[e]);
    check("ent_addr",    32'(if_a.endereco_atual), e);
    check("ent_leitura", 32'(if_a.mem_leitura), 32'd0);
    check("ent_fim",     32'(if_a.fim), 32'd0);
  endtask

  // Starts in the LE cycle of entry e, ends in the cycle after its transfer.
  task automatic do_entry(input int e, input int stall, input bit pulse_start);
    check("le_leitura", 32'(if_a.mem_leitura), 32'd1);
    check("le_addr",    32'(if_a.mem_endereco), e);
    check("le_valido",  32'(if_a.valido), 32'd0);
    check("le_ocupado", 32'(if_a.ocupado), 32'd1);
    tick();
    check("es_leitura", 32'(if_a.mem_leitura), 32'd0);
    check("es_addr",    32'(if_a.mem_endereco), 32'd0);
    check("es_valido",  32'(if_a.valido), 32'd0);
    if (stall > 0) if_a.pronto = 1'b0;
    tick();
    for (int s = 0; s < stall; s++) begin
      check_entrega(e);
      tick();
    end
    if_a.pronto = 1'b1;
    check_entrega(e);
    if (pulse_start) if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 10'b1010_0101_11;
    mem_a[1] = 10'b0001_1111_00;
    mem_a[2] = 10'b1111_0000_10;
    mem_a[3] = 10'b0110_1001_01;
    mem_b[0] = 12'b10011_01100_10;

    reset        = 1'b1;
    if_a.iniciar = 1'b1;
    if_a.pronto  = 1'b0;
    if_b.iniciar = 1'b0;
    if_b.pronto  = 1'b0;
    modo_aleat   = 1'b1;
    dado_aleat   = 10'($urandom);

    // 1. Reset with iniciar high and random memory data
    for (int i = 0; i < 2; i++) begin
      dado_aleat = 10'($urandom);
      tick();
      check_idle_a("reset_outputs");
      check("reset_b_ocupado", 32'(if_b.ocupado), 32'd0);
    end
    reset        = 1'b0;
    if_a.iniciar = 1'b0;
    modo_aleat   = 1'b0;
    tick();
    check_idle_a("after_reset");

    // 2. Full pass, consumer always ready
    if_a.pronto  = 1'b1;
    fim_ref      = n_fim_a;
    if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
    for (int e = 0; e < 4; e++) do_entry(e, 0, 1'b0);
    check("p1_fim",        32'(if_a.fim), 32'd1);
    check("p1_fim_valido", 32'(if_a.valido), 32'd0);
    check("p1_fim_ocup",   32'(if_a.ocupado), 32'd1);
    tick();
    check("p1_post_fim",   32'(if_a.fim), 32'd0);
    check("p1_post_ocup",  32'(if_a.ocupado), 32'd0);
    check("p1_fim_count",  32'(n_fim_a - fim_ref), 32'd1);

    // 3+4. Backpressure on entry 1, start pulses during entry 2 and during FIM
    fim_ref      = n_fim_a;
    if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
    do_entry(0, 0, 1'b0);
    do_entry(1, 5, 1'b0);
    do_entry(2, 0, 1'b1);
    do_entry(3, 0, 1'b0);
    check("p2_fim", 32'(if_a.fim), 32'd1);
    if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
    check("p2_post_ocup", 32'(if_a.ocupado), 32'd0);
    check("p2_post_fim",  32'(if_a.fim), 32'd0);
    tick();
    check("p2_still_idle",    32'(if_a.ocupado), 32'd0);
    check("p2_no_read",       32'(if_a.mem_leitura), 32'd0);
    check("p2_fim_count",     32'(n_fim_a - fim_ref), 32'd1);

    // 5. Reset while entry 1 is valid, then restart from address 0
    fim_ref      = n_fim_a;
    if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
    do_entry(0, 0, 1'b0);
    check("mid_le_addr", 32'(if_a.mem_endereco), 32'd1);
    tick();
    tick();
    check_entrega(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_a("mid_reset");
    tick();
    check_idle_a("mid_after_reset");
    check("mid_no_fim", 32'(n_fim_a - fim_ref), 32'd0);
    if_a.iniciar = 1'b1;
    tick();
    if_a.iniciar = 1'b0;
    for (int e = 0; e < 4; e++) do_entry(e, 0, 1'b0);
    check("restart_fim", 32'(if_a.fim), 32'd1);
    tick();
    check("restart_idle", 32'(if_a.ocupado), 32'd0);

    // 6. N=5, single entry
    fim_ref      = n_fim_b;
    if_b.pronto  = 1'b1;
    if_b.iniciar = 1'b1;
    tick();
    if_b.iniciar = 1'b0;
    check("b_le_leitura", 32'(if_b.mem_leitura), 32'd1);
    check("b_le_addr",    32'(if_b.mem_endereco), 32'd0);
    tick();
    check("b_es_valido",  32'(if_b.valido), 32'd0);
    tick();
    check("b_valido",     32'(if_b.valido), 32'd1);
    check("b_x",          32'(if_b.coor_x), 32'd19);
    check("b_y",          32'(if_b.coor_y), 32'd12);
    check("b_op",         32'(if_b.opcode), 32'd2);
    check("b_addr",       32'(if_b.endereco_atual), 32'd0);
    tick();
    check("b_fim",        32'(if_b.fim), 32'd1);
    check("b_fim_valido", 32'(if_b.valido), 32'd0);
    tick();
    check("b_post_fim",   32'(if_b.fim), 32'd0);
    check("b_post_ocup",  32'(if_b.ocupado), 32'd0);
    check("b_fim_count",  32'(n_fim_b - fim_ref), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
